// File: rtl/loop_ctrl_pkg.sv
// Shared types and default sizing for the hardware loop sequencer.
package loop_ctrl_pkg;

    localparam int unsigned LC_ADDR_W = 32;
    localparam int unsigned LC_CNT_W  = 16;
    localparam int unsigned LC_DEPTH  = 4;

    typedef struct packed {
        logic [LC_ADDR_W-1:0] start_addr;
        logic [LC_ADDR_W-1:0] end_addr;
        logic [LC_CNT_W-1:0]  remaining;
    } loop_entry_t;

endpackage

// File: rtl/loop_controller_if.sv
// Loop-setup handshake between the decode stage and the loop sequencer.
interface loop_controller_if import loop_ctrl_pkg::*; #(
    parameter int unsigned ADDR_W = LC_ADDR_W,
    parameter int unsigned CNT_W  = LC_CNT_W
);
    logic              setup_valid;
    logic [ADDR_W-1:0] setup_start;
    logic [ADDR_W-1:0] setup_end;
    logic [CNT_W-1:0]  setup_count;
    logic              setup_ready;

    modport master (
        output setup_valid, setup_start, setup_end, setup_count,
        input  setup_ready
    );

    modport slave (
        input  setup_valid, setup_start, setup_end, setup_count,
        output setup_ready
    );
endinterface

// File: rtl/loop_stack.sv
// LIFO of loop descriptors; pop+push on one edge replaces the top entry.
module loop_stack import loop_ctrl_pkg::*; #(
    parameter int unsigned ADDR_W = LC_ADDR_W,
    parameter int unsigned CNT_W  = LC_CNT_W,
    parameter int unsigned DEPTH  = LC_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   tos_dec,
    input  logic                   clear,
    input  logic [ADDR_W-1:0]      push_start,
    input  logic [ADDR_W-1:0]      push_end,
    input  logic [CNT_W-1:0]       push_count,
    output logic [ADDR_W-1:0]      tos_start,
    output logic [ADDR_W-1:0]      tos_end,
    output logic [CNT_W-1:0]       tos_remaining,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned DW = IW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] start_addr;
        logic [ADDR_W-1:0] end_addr;
        logic [CNT_W-1:0]  remaining;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         tos;
    logic [DW-1:0]  cnt;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  wr_idx;
    logic           do_push;
    logic           do_pop;
    logic           do_dec;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DW'(DEPTH));
    assign depth   = cnt;
    assign top_idx = IW'(cnt - DW'(1));

    // Clear dominates; a push into a full stack only lands when the top is leaving.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);
    assign do_dec  = tos_dec && !empty && !do_pop && !clear &&
                     (mem[top_idx].remaining > CNT_W'(1));
    assign wr_idx  = do_pop ? top_idx : IW'(cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (do_push && !do_pop) begin
            cnt <= cnt + DW'(1);
        end else if (do_pop && !do_push) begin
            cnt <= cnt - DW'(1);
        end
    end

    // Entry storage carries no reset; contents are only read while non-empty.
    always_ff @(posedge clk) begin
        if (do_dec) begin
            mem[top_idx].remaining <= mem[top_idx].remaining - CNT_W'(1);
        end
        if (do_push) begin
            mem[wr_idx] <= {push_start, push_end, push_count};
        end
    end

    assign tos           = empty ? '0 : mem[top_idx];
    assign tos_start     = tos.start_addr;
    assign tos_end       = tos.end_addr;
    assign tos_remaining = tos.remaining;
endmodule

// File: rtl/loop_controller.sv
// Zero-overhead loop sequencer: compares PC to the innermost loop end and steers PC reload.
module loop_controller import loop_ctrl_pkg::*; #(
    parameter int unsigned ADDR_W = LC_ADDR_W,
    parameter int unsigned CNT_W  = LC_CNT_W,
    parameter int unsigned DEPTH  = LC_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      pc,
    loop_controller_if.slave       setup,
    input  logic                   flush,
    output logic                   loop_end_inst,
    output logic                   loop_end_flag,
    output logic [ADDR_W-1:0]      start_addr,
    output logic                   loop_active,
    output logic [$clog2(DEPTH):0] loop_depth,
    output logic                   setup_err
);
    logic [ADDR_W-1:0] tos_start;
    logic [ADDR_W-1:0] tos_end;
    logic [CNT_W-1:0]  tos_remaining;
    logic              full;
    logic              empty;
    logic              hit;
    logic              last;
    logic              zero_count;
    logic              accept;
    logic              err_set;

    loop_stack #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk           (clk),
        .reset         (reset),
        .push          (accept),
        .pop           (hit && last),
        .tos_dec       (hit && !last),
        .clear         (flush),
        .push_start    (setup.setup_start),
        .push_end      (setup.setup_end),
        .push_count    (setup.setup_count),
        .tos_start     (tos_start),
        .tos_end       (tos_end),
        .tos_remaining (tos_remaining),
        .depth         (loop_depth),
        .full          (full),
        .empty         (empty)
    );

    assign hit  = !empty && (pc == tos_end);
    assign last = (tos_remaining == CNT_W'(1));

    assign loop_end_inst = hit;
    assign loop_end_flag = hit && last;
    assign start_addr    = empty ? '0 : tos_start;
    assign loop_active   = !empty;

    // Readiness reflects pre-edge fullness even when the top pops on the same edge.
    assign setup.setup_ready = !full;
    assign zero_count        = (setup.setup_count == '0);
    assign accept            = setup.setup_valid && !full && !zero_count;
    assign err_set           = setup.setup_valid && (full || zero_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            setup_err <= 1'b0;
        end else if (flush) begin
            setup_err <= 1'b0;
        end else if (err_set) begin
            setup_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_loop_controller.sv
// Scoreboard bench for loop_controller: a PC model drives the DUT, hits are checked against queued expectations.
module tb_loop_controller;
    import loop_ctrl_pkg::*;

    localparam int unsigned AW = LC_ADDR_W;
    localparam int unsigned CW = LC_CNT_W;
    localparam int unsigned D  = LC_DEPTH;
    localparam int unsigned DW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_init;
    logic          pc_load;
    logic          run;
    logic          flush;
    logic          loop_end_inst;
    logic          loop_end_flag;
    logic [AW-1:0] start_addr;
    logic          loop_active;
    logic [DW-1:0] loop_depth;
    logic          setup_err;

    loop_controller_if #(.ADDR_W(AW), .CNT_W(CW)) sif ();

    loop_controller #(.ADDR_W(AW), .CNT_W(CW), .DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .setup         (sif),
        .flush         (flush),
        .loop_end_inst (loop_end_inst),
        .loop_end_flag (loop_end_flag),
        .start_addr    (start_addr),
        .loop_active   (loop_active),
        .loop_depth    (loop_depth),
        .setup_err     (setup_err)
    );

    always #5 clk = ~clk;

    // Program counter: reloads on a non-final loop end, otherwise increments.
    always @(posedge clk or posedge reset) begin
        if (reset)        pc <= '0;
        else if (pc_load) pc <= pc_init;
        else if (run)     pc <= (loop_end_inst && !loop_end_flag) ? start_addr : pc + AW'(1);
    end

    typedef struct {
        logic [AW-1:0] pc;
        logic          flag;
        logic [AW-1:0] start;
        logic [DW-1:0] depth;
    } hit_t;

    hit_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_hit(input logic [AW-1:0] p, input logic f,
                              input logic [AW-1:0] s, input int d);
        hit_t h;
        h.pc = p; h.flag = f; h.start = s; h.depth = DW'(d);
        exp_q.push_back(h);
    endtask

    // Monitor: every cycle the DUT flags a loop end is compared with the next expectation.
    always @(negedge clk) begin
        hit_t e;
        if (!reset && loop_end_inst) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_hit: got pc=%0h flag=%0b expected no hit", pc, loop_end_flag);
            end else begin
                e = exp_q.pop_front();
                check("hit_pc", pc, e.pc);
                check("hit_flag", loop_end_flag, e.flag);
                check("hit_start", start_addr, e.start);
                check("hit_depth", loop_depth, e.depth);
            end
        end
    end

    task automatic setup_cmd(input loop_entry_t ent);
        sif.setup_valid = 1'b1;
        sif.setup_start = ent.start_addr;
        sif.setup_end   = ent.end_addr;
        sif.setup_count = ent.remaining;
        @(negedge clk);
        sif.setup_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [AW-1:0] v);
        pc_init = v;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic run_until(input logic [AW-1:0] target, input int max_cyc, output int cyc);
        run = 1'b1;
        cyc = 0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (pc == target) break;
        end
        run = 1'b0;
        check("reach_pc", pc, target);
    endtask

    initial begin
        int cyc;
        int body;
        reset = 1'b1; run = 1'b0; pc_load = 1'b0; pc_init = '0; flush = 1'b0;
        sif.setup_valid = 1'b0; sif.setup_start = '0; sif.setup_end = '0; sif.setup_count = '0;

        #12;
        check("rst_active", loop_active, 1'b0);
        check("rst_depth", loop_depth, 0);
        check("rst_end_inst", loop_end_inst, 1'b0);
        check("rst_end_flag", loop_end_flag, 1'b0);
        check("rst_start", start_addr, 0);
        check("rst_ready", sif.setup_ready, 1'b1);
        check("rst_err", setup_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single loop 0x10..0x13 x3 from PC 0x0C.
        load_pc(AW'(32'h0C));
        setup_cmd('{32'h10, 32'h13, 16'd3});
        check("s1_depth", loop_depth, 1);
        check("s1_start", start_addr, 32'h10);
        expect_hit(32'h13, 1'b0, 32'h10, 1);
        expect_hit(32'h13, 1'b0, 32'h10, 1);
        expect_hit(32'h13, 1'b1, 32'h10, 1);
        run_until(AW'(32'h14), 60, cyc);
        check("s1_cycles", cyc, 16);
        check("s1_depth_end", loop_depth, 0);
        check("s1_active_end", loop_active, 1'b0);

        // Nested: outer 0x20..0x2F x2, inner 0x24..0x27 x4 re-issued at 0x23.
        load_pc(AW'(32'h1E));
        setup_cmd('{32'h20, 32'h2F, 16'd2});
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < 4; i++) expect_hit(32'h27, (i == 3), 32'h24, 2);
            expect_hit(32'h2F, (o == 1), 32'h20, 1);
        end
        sif.setup_start = 32'h24; sif.setup_end = 32'h27; sif.setup_count = 16'd4;
        run = 1'b1; cyc = 0; body = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            sif.setup_valid = (pc == 32'h23);
            if (pc == 32'h24) body++;
            if (pc == 32'h30) break;
        end
        run = 1'b0;
        sif.setup_valid = 1'b0;
        check("s2_reach_pc", pc, 32'h30);
        check("s2_inner_body", body, 8);
        check("s2_depth_end", loop_depth, 0);
        check("s2_err", setup_err, 1'b0);

        // Overflow: fill the stack, then one more setup.
        load_pc('0);
        for (int i = 0; i < 4; i++) begin
            setup_cmd('{AW'(32'h100 + i * 16), AW'(32'h200 + i), 16'd5});
            check("s3_depth_fill", loop_depth, i + 1);
        end
        check("s3_ready_full", sif.setup_ready, 1'b0);
        setup_cmd('{32'h500, 32'h600, 16'd7});
        check("s3_depth_over", loop_depth, 4);
        check("s3_err_over", setup_err, 1'b1);
        check("s3_tos_start", start_addr, 32'h130);
        expect_hit(32'h203, 1'b0, 32'h130, 4);
        load_pc(AW'(32'h203));
        load_pc('0);
        do_flush();
        check("s3_flush_depth", loop_depth, 0);
        check("s3_flush_err", setup_err, 1'b0);
        check("s3_flush_ready", sif.setup_ready, 1'b1);

        // Zero count: nothing pushed, sticky error until flush.
        setup_cmd('{32'h70, 32'h73, 16'd0});
        check("s4_active", loop_active, 1'b0);
        check("s4_err", setup_err, 1'b1);
        do_flush();
        check("s4_err_flush", setup_err, 1'b0);

        // Setup on the same edge as the final-iteration pop.
        load_pc(AW'(32'h40));
        setup_cmd('{32'h40, 32'h41, 16'd1});
        expect_hit(32'h41, 1'b1, 32'h40, 1);
        run = 1'b1;
        @(negedge clk);
        sif.setup_valid = 1'b1;
        sif.setup_start = 32'h50; sif.setup_end = 32'h53; sif.setup_count = 16'd2;
        check("s5_ready_pre", sif.setup_ready, 1'b1);
        @(negedge clk);
        run = 1'b0;
        sif.setup_valid = 1'b0;
        check("s5_pc", pc, 32'h42);
        check("s5_depth", loop_depth, 1);
        check("s5_new_tos", start_addr, 32'h50);
        expect_hit(32'h53, 1'b0, 32'h50, 1);
        load_pc(AW'(32'h53));
        load_pc('0);
        do_flush();

        // Asynchronous reset while two loops are live.
        setup_cmd('{32'h60, 32'h6F, 16'd3});
        setup_cmd('{32'h64, 32'h67, 16'd3});
        setup_cmd('{32'h0, 32'h0, 16'd0});
        check("s6_depth", loop_depth, 2);
        check("s6_err", setup_err, 1'b1);
        expect_hit(32'h67, 1'b0, 32'h64, 2);
        load_pc(AW'(32'h67));
        #2 reset = 1'b1;
        #1;
        check("s6_rst_inst", loop_end_inst, 1'b0);
        check("s6_rst_flag", loop_end_flag, 1'b0);
        check("s6_rst_start", start_addr, 0);
        check("s6_rst_active", loop_active, 1'b0);
        check("s6_rst_depth", loop_depth, 0);
        check("s6_rst_err", setup_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("s6_ready_after", sif.setup_ready, 1'b1);
        check("s6_depth_after", loop_depth, 0);

        check("pending_hits", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
